// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_pkg
// Brief    : Shared TAP types and constants. This package defines the
//            16-state TAP encoding, the default instruction codes, the BYPASS
//            fill bit and the 1149.1 next-state function.
// Revision : 1.0 - initial release
// ============================================================================
package jtag_pkg;

   typedef enum logic [3:0] {
      S_TLR      = 4'h0,
      S_RTI      = 4'h1,
      S_SEL_DR   = 4'h2,
      S_CAP_DR   = 4'h3,
      S_SH_DR    = 4'h4,
      S_EX1_DR   = 4'h5,
      S_PAUSE_DR = 4'h6,
      S_EX2_DR   = 4'h7,
      S_UPD_DR   = 4'h8,
      S_SEL_IR   = 4'h9,
      S_CAP_IR   = 4'hA,
      S_SH_IR    = 4'hB,
      S_EX1_IR   = 4'hC,
      S_PAUSE_IR = 4'hD,
      S_EX2_IR   = 4'hE,
      S_UPD_IR   = 4'hF
   } tap_state_e;

   localparam logic [3:0]  c_IR_IDCODE      = 4'h1;
   localparam logic [3:0]  c_IR_GPIO_DATA   = 4'h2;
   localparam logic [3:0]  c_IR_GPIO_CONFIG = 4'h3;
   localparam logic [31:0] c_IDCODE_VALUE   = 32'h1000_0001;
   // The BYPASS instruction is every IR bit set to this value.
   localparam logic        c_BYPASS_BIT     = 1'b1;

   // 1149.1 TAP transition table.
   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      tap_state_e n;
      case (s)
         S_TLR:      n = tms ? S_TLR    : S_RTI;
         S_RTI:      n = tms ? S_SEL_DR : S_RTI;
         S_SEL_DR:   n = tms ? S_SEL_IR : S_CAP_DR;
         S_CAP_DR:   n = tms ? S_EX1_DR : S_SH_DR;
         S_SH_DR:    n = tms ? S_EX1_DR : S_SH_DR;
         S_EX1_DR:   n = tms ? S_UPD_DR : S_PAUSE_DR;
         S_PAUSE_DR: n = tms ? S_EX2_DR : S_PAUSE_DR;
         S_EX2_DR:   n = tms ? S_UPD_DR : S_SH_DR;
         S_UPD_DR:   n = tms ? S_SEL_DR : S_RTI;
         S_SEL_IR:   n = tms ? S_TLR    : S_CAP_IR;
         S_CAP_IR:   n = tms ? S_EX1_IR : S_SH_IR;
         S_SH_IR:    n = tms ? S_EX1_IR : S_SH_IR;
         S_EX1_IR:   n = tms ? S_UPD_IR : S_PAUSE_IR;
         S_PAUSE_IR: n = tms ? S_EX2_IR : S_PAUSE_IR;
         S_EX2_IR:   n = tms ? S_UPD_IR : S_SH_IR;
         S_UPD_IR:   n = tms ? S_SEL_DR : S_RTI;
         default:    n = S_TLR;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_fsm
// Brief    : TAP state register, next-state logic and state-decode strobes.
//            The strobes are registered from the next state, so each output
//            is a clean flop equal to the decode of the current state.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_tms,
   output logic o_test_logic_reset,
   output logic o_capture_dr,
   output logic o_shift_dr,
   output logic o_update_dr,
   output logic o_capture_ir,
   output logic o_shift_ir,
   output logic o_update_ir
);

   tap_state_e r_state;
   tap_state_e w_next;
   logic       r_tlr;
   logic       r_cap_dr;
   logic       r_sh_dr;
   logic       r_upd_dr;
   logic       r_cap_ir;
   logic       r_sh_ir;
   logic       r_upd_ir;

   // Next state from the current state and TMS.
   always_comb begin
      w_next = tap_next(r_state, i_tms);
   end

   // State register with strobes registered alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_TLR;
         r_tlr    <= 1'b1;
         r_cap_dr <= 1'b0;
         r_sh_dr  <= 1'b0;
         r_upd_dr <= 1'b0;
         r_cap_ir <= 1'b0;
         r_sh_ir  <= 1'b0;
         r_upd_ir <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_tlr    <= (w_next == S_TLR);
         r_cap_dr <= (w_next == S_CAP_DR);
         r_sh_dr  <= (w_next == S_SH_DR);
         r_upd_dr <= (w_next == S_UPD_DR);
         r_cap_ir <= (w_next == S_CAP_IR);
         r_sh_ir  <= (w_next == S_SH_IR);
         r_upd_ir <= (w_next == S_UPD_IR);
      end
   end

   assign o_test_logic_reset = r_tlr;
   assign o_capture_dr       = r_cap_dr;
   assign o_shift_dr         = r_sh_dr;
   assign o_update_dr        = r_upd_dr;
   assign o_capture_ir       = r_cap_ir;
   assign o_shift_ir         = r_sh_ir;
   assign o_update_ir        = r_upd_ir;

endmodule
`default_nettype wire

// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_ctrl
// Brief    : TAP controller for the GPIO scan chains. It contains the
//            instruction register, the IDCODE and BYPASS data registers,
//            the instruction decodes and the TDO mux.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter int                 IR_BITS        = 4,
   parameter logic [31:0]        IDCODE_VALUE   = c_IDCODE_VALUE,
   parameter logic [IR_BITS-1:0] IR_IDCODE      = IR_BITS'(c_IR_IDCODE),
   parameter logic [IR_BITS-1:0] IR_GPIO_DATA   = IR_BITS'(c_IR_GPIO_DATA),
   parameter logic [IR_BITS-1:0] IR_GPIO_CONFIG = IR_BITS'(c_IR_GPIO_CONFIG)
) (
   input  logic tck,
   input  logic reset,
   input  logic tms,
   input  logic tdi,
   output logic tdo,
   output logic tdo_ena,
   input  logic gpios_tdo,
   output logic test_logic_reset,
   output logic capture_dr,
   output logic shift_dr,
   output logic update_dr,
   output logic gpio_data_ir,
   output logic gpio_config_ir
);

   localparam logic [IR_BITS-1:0] c_BYPASS_CODE = {IR_BITS{c_BYPASS_BIT}};

   logic               w_tlr;
   logic               w_cap_dr;
   logic               w_sh_dr;
   logic               w_upd_dr;
   logic               w_cap_ir;
   logic               w_sh_ir;
   logic               w_upd_ir;
   logic [IR_BITS-1:0] r_ir;
   logic [IR_BITS-1:0] r_ir_sr;
   logic [31:0]        r_idcode_sr;
   logic               r_bypass;
   logic               w_sel_idcode;
   logic               w_sel_data;
   logic               w_sel_config;
   logic               w_sel_bypass;
   logic               w_tdo;

   jtag_tap_fsm u_fsm (
      .clk                (tck),
      .rst                (reset),
      .i_tms              (tms),
      .o_test_logic_reset (w_tlr),
      .o_capture_dr       (w_cap_dr),
      .o_shift_dr         (w_sh_dr),
      .o_update_dr        (w_upd_dr),
      .o_capture_ir       (w_cap_ir),
      .o_shift_ir         (w_sh_ir),
      .o_update_ir        (w_upd_ir)
   );

   // Instruction decodes come from the latched IR only; any code that is
   // not one of the three named instructions falls through to BYPASS.
   assign w_sel_idcode = (r_ir == IR_IDCODE);
   assign w_sel_data   = (r_ir == IR_GPIO_DATA);
   assign w_sel_config = (r_ir == IR_GPIO_CONFIG);
   assign w_sel_bypass = (r_ir == c_BYPASS_CODE) ||
                         !(w_sel_idcode || w_sel_data || w_sel_config);

   // Instruction register and its shift stage; TLR reloads IDCODE.
   always_ff @(posedge tck) begin
      if (reset || w_tlr) begin
         r_ir    <= IR_IDCODE;
         r_ir_sr <= '0;
      end else begin
         if (w_cap_ir) begin
            r_ir_sr <= IR_BITS'(2'b01);
         end else if (w_sh_ir) begin
            r_ir_sr <= {tdi, r_ir_sr[IR_BITS-1:1]};
         end
         if (w_upd_ir) begin
            r_ir <= r_ir_sr;
         end
      end
   end

   // IDCODE data register, active only while IDCODE is selected.
   always_ff @(posedge tck) begin
      if (reset) begin
         r_idcode_sr <= IDCODE_VALUE;
      end else if (w_sel_idcode) begin
         if (w_cap_dr) begin
            r_idcode_sr <= IDCODE_VALUE;
         end else if (w_sh_dr) begin
            r_idcode_sr <= {tdi, r_idcode_sr[31:1]};
         end
      end
   end

   // BYPASS flop, active only while BYPASS is selected.
   always_ff @(posedge tck) begin
      if (reset) begin
         r_bypass <= 1'b0;
      end else if (w_sel_bypass) begin
         if (w_cap_dr) begin
            r_bypass <= 1'b0;
         end else if (w_sh_dr) begin
            r_bypass <= tdi;
         end
      end
   end

   // TDO mux: the selected chain's LSB while shifting, otherwise 0.
   always_comb begin
      w_tdo = 1'b0;
      if (w_sh_ir) begin
         w_tdo = r_ir_sr[0];
      end else if (w_sh_dr) begin
         if (w_sel_idcode) begin
            w_tdo = r_idcode_sr[0];
         end else if (w_sel_data || w_sel_config) begin
            w_tdo = gpios_tdo;
         end else begin
            w_tdo = r_bypass;
         end
      end
   end

   assign tdo              = w_tdo;
   assign tdo_ena          = w_sh_ir | w_sh_dr;
   assign test_logic_reset = w_tlr;
   assign capture_dr       = w_cap_dr;
   assign shift_dr         = w_sh_dr;
   assign update_dr        = w_upd_dr;
   assign gpio_data_ir     = w_sel_data;
   assign gpio_config_ir   = w_sel_config;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_tap_ctrl
// Brief    : Scoreboard bench for jtag_tap_ctrl. A reference model predicts
//            every cycle's outputs; a monitor compares them at the falling
//            edge. Directed test-plan scans precede a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_ctrl;

   localparam logic [31:0] IDV = 32'h1000_0001;

   // Model state numbering: 0 TLR,1 RTI,2 SelDR,3 CapDR,4 ShDR,5 Ex1DR,
   // 6 PauseDR,7 Ex2DR,8 UpdDR,9 SelIR,10 CapIR,11 ShIR,12 Ex1IR,
   // 13 PauseIR,14 Ex2IR,15 UpdIR.
   int NX0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
   int NX1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

   logic tck = 1'b0;
   logic reset, tms, tdi, tdo, tdo_ena, gpios_tdo;
   logic tlr, cap, sh, upd, dir, cir;
   logic [7:0] gpio_inputs, g_sr, g_out;

   int n_checks = 0;
   int n_fail   = 0;
   int n_upd    = 0;
   int n_cap    = 0;

   logic [7:0] exp_q [$];

   int         m_st;
   logic [3:0] m_ir, m_irsr;
   logic [31:0] m_id;
   logic       m_byp;

   always #5 tck = ~tck;

   jtag_tap_ctrl dut (
      .tck              (tck),
      .reset            (reset),
      .tms              (tms),
      .tdi              (tdi),
      .tdo              (tdo),
      .tdo_ena          (tdo_ena),
      .gpios_tdo        (gpios_tdo),
      .test_logic_reset (tlr),
      .capture_dr       (cap),
      .shift_dr         (sh),
      .update_dr        (upd),
      .gpio_data_ir     (dir),
      .gpio_config_ir   (cir)
   );

   // Stand-in for an 8-bit jtag_gpios data chain.
   always @(posedge tck) begin
      if (reset) begin
         g_sr  <= 8'h00;
         g_out <= 8'h00;
      end else if (dir) begin
         if (cap)     g_sr <= gpio_inputs;
         else if (sh) g_sr <= {tdi, g_sr[7:1]};
         if (upd)     g_out <= g_sr;
      end
   end
   assign gpios_tdo = g_sr[0];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Expected {tdo, tdo_ena, tlr, capture_dr, shift_dr, update_dr, data_ir, config_ir}.
   function automatic logic [7:0] model_expect();
      logic e_tdo;
      e_tdo = 1'b0;
      if (m_st == 11) e_tdo = m_irsr[0];
      else if (m_st == 4) begin
         if (m_ir == 4'h1) e_tdo = m_id[0];
         else if (m_ir == 4'h2 || m_ir == 4'h3) e_tdo = gpios_tdo;
         else e_tdo = m_byp;
      end
      return {e_tdo, (m_st == 4 || m_st == 11), (m_st == 0), (m_st == 3),
              (m_st == 4), (m_st == 8), (m_ir == 4'h2), (m_ir == 4'h3)};
   endfunction

   task automatic model_edge(input logic t, input logic d, input logic r);
      logic is_id, is_byp;
      is_id  = (m_ir == 4'h1);
      is_byp = !(m_ir == 4'h1 || m_ir == 4'h2 || m_ir == 4'h3);
      if (r) begin
         m_st = 0; m_ir = 4'h1; m_irsr = 4'h0; m_id = IDV; m_byp = 1'b0;
      end else begin
         case (m_st)
            0:  m_ir = 4'h1;
            10: m_irsr = 4'b0001;
            11: m_irsr = {d, m_irsr[3:1]};
            15: m_ir = m_irsr;
            3:  begin
                   if (is_id) m_id = IDV;
                   if (is_byp) m_byp = 1'b0;
                end
            4:  begin
                   if (is_id) m_id = {d, m_id[31:1]};
                   if (is_byp) m_byp = d;
                end
            default: ;
         endcase
         m_st = t ? NX1[m_st] : NX0[m_st];
      end
   endtask

   // One TCK cycle: queue the prediction, drive inputs, sample tdo, advance model.
   task automatic step(input logic t, input logic d, input logic r, output logic b);
      exp_q.push_back(model_expect());
      tms = t; tdi = d; reset = r;
      @(negedge tck);
      b = tdo;
      if (upd) n_upd++;
      if (cap) n_cap++;
      @(posedge tck);
      #2;
      model_edge(t, d, r);
   endtask

   task automatic tms_seq(input int n, input logic [15:0] bits);
      logic b;
      for (int i = 0; i < n; i++) step(bits[i], 1'b0, 1'b0, b);
   endtask

   // n shift cycles, TMS=1 on the last; returns the tdo bits LSB-first.
   task automatic shift(input int n, input logic [31:0] din, output logic [31:0] dout);
      logic b;
      dout = '0;
      for (int i = 0; i < n; i++) begin
         step(i == n - 1, din[i], 1'b0, b);
         dout[i] = b;
      end
   endtask

   task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
      tms_seq(3, 16'b001);
      shift(n, din, dout);
      tms_seq(2, 16'b01);
   endtask

   task automatic load_ir(input logic [3:0] code, output logic [3:0] cap_bits);
      logic [31:0] o;
      tms_seq(4, 16'b0011);
      shift(4, {28'h0, code}, o);
      cap_bits = o[3:0];
      tms_seq(2, 16'b01);
   endtask

   // Scoreboard monitor.
   initial begin
      logic [7:0] e, a;
      forever begin
         @(negedge tck);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {tdo, tdo_ena, tlr, cap, sh, upd, dir, cir};
            n_checks++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL scoreboard t=%0t got=%b expected=%b (tdo,ena,tlr,cap,sh,upd,dir,cir)",
                        $time, a, e);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v, a, c;
      logic [3:0]  irc;
      logic        b, t, d, r;
      reset = 1'b1; tms = 1'b1; tdi = 1'b0; gpio_inputs = 8'hA5;
      repeat (2) @(posedge tck);
      #2;
      model_edge(1'b1, 1'b0, 1'b1);
      check("reset_state", 64'({tlr, cap, sh, upd, dir, cir, tdo, tdo_ena}), 64'(8'b1000_0000));

      tms_seq(1, 16'b0);
      n_upd = 0;
      dr_scan(32, $urandom, v);
      check("idcode_read", 64'(v), 64'(IDV));
      check("idcode_upd_pulses", 64'(n_upd), 64'd1);

      load_ir(4'h2, irc);
      check("ir_capture_bits", 64'(irc), 64'(4'b0001));
      check("data_ir_sel", 64'({dir, cir}), 64'(2'b10));
      load_ir(4'h3, irc);
      check("config_ir_sel", 64'({dir, cir}), 64'(2'b01));

      load_ir(4'h2, irc);
      dr_scan(8, 32'h3C, v);
      check("gpio_tdo", 64'(v[7:0]), 64'(8'hA5));
      check("gpio_update", 64'(g_out), 64'(8'h3C));

      load_ir(4'h7, irc);
      check("bypass_no_gpio_sel", 64'({dir, cir}), 64'(2'b00));
      dr_scan(4, 32'b1101, v);
      check("bypass_tdo", 64'(v[3:0]), 64'(4'b1010));

      load_ir(4'h1, irc);
      n_cap = 0; n_upd = 0;
      tms_seq(3, 16'b001);
      shift(10, $urandom, a);
      tms_seq(5, 16'b01000);
      shift(22, $urandom, c);
      tms_seq(2, 16'b01);
      check("pause_idcode", 64'({c[21:0], a[9:0]}), 64'(IDV));
      check("pause_capture_count", 64'(n_cap), 64'd1);
      check("pause_update_count", 64'(n_upd), 64'd1);

      load_ir(4'h3, irc);
      n_upd = 0;
      tms_seq(6, 16'b000001);
      step(1'b0, 1'b1, 1'b1, b);
      check("reset_mid_shift", 64'({tlr, cap, sh, upd, dir, cir, tdo_ena}), 64'(7'b1000000));
      check("reset_no_update", 64'(n_upd), 64'd0);
      tms_seq(1, 16'b0);
      dr_scan(32, $urandom, v);
      check("idcode_after_reset", 64'(v), 64'(IDV));

      load_ir(4'h2, irc);
      tms_seq(5, 16'b11111);
      check("five_tms_tlr", 64'({tlr, dir}), 64'(2'b10));

      tms_seq(1, 16'b0);
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         t = ($urandom_range(0, 99) < 35);
         d = 1'($urandom);
         if ($urandom_range(0, 63) == 0) gpio_inputs = 8'($urandom);
         step(t, d, r, b);
      end

      @(negedge tck);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
